// File: rtl/wb_regfile_unit_pkg.sv
// Shared widths, writeback-select encodings and the writeback bundle type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_regfile_unit_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Writeback source select, as encoded by the decode stage.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  // The writeback as it leaves this block towards EX-stage forwarding.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  write_en;
  } wb_port_t;

endpackage

// File: rtl/wb_regfile_unit_mux.sv
// Writeback source selector: picks one of four data candidates.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: sel (2b select), alu_result / dmem_out / pc_4 / immediate (XLEN candidates),
//        data (XLEN selected writeback value).
module wb_mux
  import wb_regfile_unit_pkg::*;
(
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] dmem_out,
  input  logic [XLEN-1:0] pc_4,
  input  logic [XLEN-1:0] immediate,
  output logic [XLEN-1:0] data
);

  always_comb begin
    data = alu_result;
    case (wb_sel_e'(sel))
      WB_ALU:  data = alu_result;
      WB_MEM:  data = dmem_out;
      WB_PC4:  data = pc_4;
      WB_IMM:  data = immediate;
      default: data = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_regfile_unit.sv
// Writeback stage plus 2-read/1-write integer register file with write-before-read bypass.
// Latency: reads and writeback outputs combinational; register write commits on the CLK edge.
// Backpressure: none; a write request is always accepted on the edge it is presented.
// Ports: CLK/RST_N; IN_RD, IN_WB_SEL, IN_REG_WRITE_EN and four data candidates from the
//        writeback pipeline register; IN_RSx_ADDR -> OUT_RSx_DATA read ports; OUT_WB_* export
//        the current writeback for forwarding; OUT_WB_COUNT counts committed writes.
module wb_regfile_unit
  import wb_regfile_unit_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [REG_ADDR_W-1:0] IN_RD,
  input  logic [XLEN-1:0]       IN_PC_4,
  input  logic [XLEN-1:0]       IN_ALU_RESULT,
  input  logic [XLEN-1:0]       IN_IMMEDIATE,
  input  logic [XLEN-1:0]       IN_DMEM_OUT,
  input  logic [1:0]            IN_WB_SEL,
  input  logic                  IN_REG_WRITE_EN,
  input  logic [REG_ADDR_W-1:0] IN_RS1_ADDR,
  input  logic [REG_ADDR_W-1:0] IN_RS2_ADDR,
  output logic [XLEN-1:0]       OUT_RS1_DATA,
  output logic [XLEN-1:0]       OUT_RS2_DATA,
  output logic [REG_ADDR_W-1:0] OUT_WB_RD,
  output logic [XLEN-1:0]       OUT_WB_DATA,
  output logic                  OUT_WB_WRITE_EN,
  output logic [XLEN-1:0]       OUT_WB_COUNT
);

  wb_port_t        wb;
  logic [XLEN-1:0] wb_data;
  logic            write_req;
  logic [XLEN-1:0] regs [1:NUM_REGS-1];  // x0 is hard-wired, never stored
  logic [XLEN-1:0] wb_count;

  wb_mux u_wb_mux (
    .sel        (IN_WB_SEL),
    .alu_result (IN_ALU_RESULT),
    .dmem_out   (IN_DMEM_OUT),
    .pc_4       (IN_PC_4),
    .immediate  (IN_IMMEDIATE),
    .data       (wb_data)
  );

  // Case-equality so an unknown write request resolves to "no write" rather than
  // propagating X into the register array and the counter.
  assign write_req = (IN_REG_WRITE_EN === 1'b1);

  // Reset is folded in so nothing can commit or bypass while RST_N is low.
  always_comb begin
    wb.rd       = IN_RD;
    wb.data     = wb_data;
    wb.write_en = RST_N && write_req && (IN_RD != '0);
  end

  assign OUT_WB_RD       = wb.rd;
  assign OUT_WB_DATA     = wb.data;
  assign OUT_WB_WRITE_EN = wb.write_en;
  assign OUT_WB_COUNT    = wb_count;

  // Read ports: x0 and reset force zero; a same-cycle write to the read address
  // wins over the stored value (write-before-read).
  always_comb begin
    OUT_RS1_DATA = '0;
    if (RST_N && (IN_RS1_ADDR != '0)) begin
      if (wb.write_en && (IN_RS1_ADDR == wb.rd)) OUT_RS1_DATA = wb.data;
      else                                      OUT_RS1_DATA = regs[IN_RS1_ADDR];
    end
  end

  always_comb begin
    OUT_RS2_DATA = '0;
    if (RST_N && (IN_RS2_ADDR != '0)) begin
      if (wb.write_en && (IN_RS2_ADDR == wb.rd)) OUT_RS2_DATA = wb.data;
      else                                      OUT_RS2_DATA = regs[IN_RS2_ADDR];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb.write_en) begin
      regs[wb.rd] <= wb.data;
    end
  end

  // Free-running wrap at all-ones is intended.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)           wb_count <= '0;
    else if (wb.write_en) wb_count <= wb_count + 1'b1;
  end

endmodule

// File: doc/wb_regfile_unit.md
WB_REGFILE_UNIT -- requirements
Module: wb_regfile_unit

Interface
REQ-001 SHALL have: CLK  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have: RST_N  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: IN_RD  input  5  destination register index from the writeback pipeline register (instruction bits [11:7]).
REQ-004 SHALL have: IN_PC_4, IN_ALU_RESULT, IN_IMMEDIATE, IN_DMEM_OUT  input  32 each  writeback data candidates.
REQ-005 SHALL have: IN_WB_SEL  input  2  writeback source select; IN_REG_WRITE_EN  input  1  register write request.
REQ-006 SHALL have: IN_RS1_ADDR, IN_RS2_ADDR  input  5 each  decode-stage read addresses.
REQ-007 SHALL have: OUT_RS1_DATA, OUT_RS2_DATA  output  32 each  read data.
REQ-008 SHALL have: OUT_WB_RD  output  5, OUT_WB_DATA  output  32, OUT_WB_WRITE_EN  output  1  current writeback, exported for EX-stage forwarding.
REQ-009 SHALL have: OUT_WB_COUNT  output  32  count of committed register writes.

Function
REQ-010 SHALL select OUT_WB_DATA combinationally: WB_SEL 00 = IN_ALU_RESULT, 01 = IN_DMEM_OUT, 10 = IN_PC_4, 11 = IN_IMMEDIATE.
REQ-011 SHALL drive OUT_WB_RD = IN_RD combinationally.
REQ-012 SHALL assert OUT_WB_WRITE_EN only when IN_REG_WRITE_EN === 1 and IN_RD != 0; any X/Z on IN_REG_WRITE_EN SHALL be treated as 0.
REQ-013 SHALL hold 31 general registers x1..x31, 32 bits each; x0 SHALL always read 0 and never be stored.
REQ-014 SHALL write OUT_WB_DATA into register IN_RD on the rising CLK edge where OUT_WB_WRITE_EN = 1; otherwise no register changes.
REQ-015 SHALL provide combinational reads; latency zero from address change to OUT_RSx_DATA.
REQ-016 SHALL bypass: if OUT_WB_WRITE_EN = 1 and IN_RSx_ADDR == IN_RD, OUT_RSx_DATA = OUT_WB_DATA in the same cycle (write-before-read), independently for each port.
REQ-017 SHALL return 0 on a port whose address is 0, even when IN_RD = 0 with IN_REG_WRITE_EN = 1.
REQ-018 SHALL serve both ports reading the same register, including the bypassed register, with identical data.
REQ-019 SHALL increment OUT_WB_COUNT by 1 on each edge committing a write (REQ-014); writes to x0 SHALL NOT count; 0xFFFF_FFFF SHALL wrap to 0.

Reset
REQ-020 SHALL, while RST_N = 0, asynchronously clear x1..x31 and OUT_WB_COUNT to 0, and suppress all writes.
REQ-021 SHALL keep OUT_RS1_DATA/OUT_RS2_DATA = 0 during reset, bypass included; OUT_WB_DATA and OUT_WB_RD SHALL still follow the inputs, and OUT_WB_WRITE_EN SHALL be 0.
REQ-022 SHALL, on reset assertion coincident with a write edge, discard the write; the first write SHALL commit on the first rising edge with RST_N = 1.

Structure
REQ-023 SHALL take from the shared package: XLEN = 32, REG_ADDR_W = 5, and the WB_SEL encodings (WB_ALU, WB_MEM, WB_PC4, WB_IMM).
REQ-024 SHALL instantiate one sub-module, wb_mux, implementing REQ-010; storage, bypass and counter SHALL reside in wb_regfile_unit.

Verification
REQ-025 SHALL cover: after reset, RD = 5, WB_SEL = 00, ALU = 0x1234_5678, WE = 1 for one edge; RS1 = 5 -> RS1_DATA = 0x1234_5678, WB_COUNT = 1.
REQ-026 SHALL cover: RD = 0, WE = 1, DMEM = 0xDEAD_BEEF, WB_SEL = 01; RS1 = RS2 = 0 -> both 0, WB_COUNT unchanged, WB_WRITE_EN = 0.
REQ-027 SHALL cover: x7 = 0x11; same cycle RD = 7, WB_SEL = 10, PC_4 = 0x0000_0104, WE = 1, RS1 = RS2 = 7 -> both 0x0000_0104 before the edge.
REQ-028 SHALL cover: each WB_SEL value with distinct inputs (0xA, 0xB, 0xC, 0xD) -> OUT_WB_DATA matches, stored value matches.
REQ-029 SHALL cover: WE = X after reset -> no write, WB_COUNT = 0; count forced near wrap via 0xFFFF_FFFF+1 writes model or backdoor -> wraps to 0.
REQ-030 SHALL cover: RST_N pulsed low mid-sequence between edges -> all registers and WB_COUNT read 0 immediately, next committed write counts as 1.
